vx_writeback_arb: RTL and testbench
===================================

// Module: vx_writeback_arb
// PURPOSE
//  Commit/writeback stage directly downstream of the execute stage. Merges the per-unit commit streams
//  (alu, ld, st, csr, fpu, gpu) into one register-file writeback stream, one commit per cycle.
//  Arbitration is round-robin. Output is a registered, backpressured valid/ready stage.
//  Also reports the retired-thread count per accepted end-of-packet commit to the CSR unit (instret).
// PARAMETERS
//  NUM_SRCS     6   number of commit sources; index 0 = alu ... 5 = gpu
//  NUM_WARPS    4   warps per core
//  NUM_THREADS  4   threads per warp
//  NW_BITS      $clog2(NUM_WARPS), minimum 1; warp-id width
// PORTS
//  clk        in   1                        clock; single clock domain
//  reset      in   1                        synchronous, active-high reset
//  in_valid   in   NUM_SRCS                 per-source commit valid
//  in_ready   out  NUM_SRCS                 per-source accept; a transfer occurs when valid&ready
//  in_wid     in   NUM_SRCS*NW_BITS         warp id
//  in_tmask   in   NUM_SRCS*NUM_THREADS     active-thread mask
//  in_pc      in   NUM_SRCS*32              instruction PC
//  in_rd      in   NUM_SRCS*5               destination register
//  in_wb      in   NUM_SRCS                 1 = writes the register file
//  in_eop     in   NUM_SRCS                 last commit of this instruction
//  in_data    in   NUM_SRCS*NUM_THREADS*32  per-thread result
//  wb_valid   out  1                        writeback valid (registered)
//  wb_ready   in   1                        writeback accept from the register file
//  wb_wid/wb_tmask/wb_pc/wb_rd/wb_data/wb_eop  out  (as inputs, single slot)  writeback payload (registered)
//  cmt_valid  out  1                        one retire event (registered)
//  cmt_size   out  $clog2(NUM_THREADS)+1    popcount of the retired tmask
// BEHAVIOUR
//  - Reset: wb_valid=0, cmt_valid=0, cmt_size=0, in_ready=0, RR pointer=0. Payload registers are don't-care.
//  - The output can accept (out_free) when !wb_valid || wb_ready.
//  - A source is eligible when in_valid[i] && (!in_wb[i] || out_free). Non-writeback commits (stores,
//    wb=0) never stall on the writeback port.
//  - Grant: at most one eligible source per cycle. Search is round-robin starting at ptr.
//    in_ready = onehot(grant) and is combinational from valid/wb/out_free/ptr.
//    in_ready never depends on in_ready itself.
//  - After a grant to g, ptr <= (g+1) mod NUM_SRCS. Without a grant, ptr holds.
//    Wrap: a grant to NUM_SRCS-1 sets ptr=0.
//  - Granted with wb=1: the payload loads into the wb registers; wb_valid=1 on the next cycle.
//    Latency is 1 cycle from input handshake to wb_valid.
//  - Granted with wb=0: the commit is consumed and wb_valid is not set by it. If wb_valid&&wb_ready,
//    wb_valid falls to 0 that cycle.
//  - wb_valid&&wb_ready with no new wb grant: wb_valid <= 0. A simultaneous drain and new wb grant
//    reloads the registers and keeps wb_valid=1, giving full throughput of 1 commit/cycle.
//  - While wb_valid&&!wb_ready, the wb payload is held stable. Only wb=0 sources may be granted.
//  - Retire: on any accepted commit with eop=1, the next cycle shows cmt_valid=1 and
//    cmt_size=popcount(tmask). Otherwise cmt_valid=0. This is independent of wb.
//  - A commit with tmask=0 is accepted normally; with eop=1 it produces cmt_size=0.
//  - Reset mid-operation: a pending writeback is dropped (wb_valid=0 next cycle), no retire is
//    reported, and ptr returns to 0.
//  - Unused input bits (e.g. in_data with wb=0) must not affect any output.
// TESTING
//  1. Single alu commit: wid=1, tmask=4'b1011, rd=5, wb=1, eop=1, wb_ready=1.
//     -> wb_valid in cycle+1 with the same payload; cmt_valid=1, cmt_size=3 in cycle+1.
//  2. All 6 sources valid every cycle with wb=1, wb_ready=1.
//     -> grants 0,1,2,3,4,5,0 on consecutive cycles; 6 wb beats in 6 cycles with no bubble.
//  3. wb_valid held with wb_ready=0 for 4 cycles; alu wb=1 and st wb=0 both valid.
//     -> st is accepted and the alu is stalled; wb payload is unchanged; alu is accepted in the
//     cycle wb_ready rises.
//  4. Source 5 granted (ptr=5), then sources 0 and 5 both valid.
//     -> ptr wraps to 0 and source 0 is granted first.
//  5. Commit with eop=0 followed by the same instruction with eop=1, tmask=4'b1111.
//     -> exactly one cmt_valid, with cmt_size=4.
//  6. reset asserted while wb_valid=1 and wb_ready=0.
//     -> next cycle wb_valid=0, cmt_valid=0, in_ready=0; after release the first grant goes to the
//     lowest-index valid source.

Source files
------------

// File: rtl/vx_writeback_arb.sv
// Commit/writeback arbiter: round-robin merge of per-unit commit streams
// into one registered, backpressured register-file writeback port.
module vx_writeback_arb #(
  parameter int NUM_SRCS    = 6,
  parameter int NUM_WARPS   = 4,
  parameter int NUM_THREADS = 4,
  parameter int NW_BITS     = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [NUM_SRCS-1:0]             in_valid,
  output logic [NUM_SRCS-1:0]             in_ready,
  input  logic [NUM_SRCS*NW_BITS-1:0]     in_wid,
  input  logic [NUM_SRCS*NUM_THREADS-1:0] in_tmask,
  input  logic [NUM_SRCS*32-1:0]          in_pc,
  input  logic [NUM_SRCS*5-1:0]           in_rd,
  input  logic [NUM_SRCS-1:0]             in_wb,
  input  logic [NUM_SRCS-1:0]             in_eop,
  input  logic [NUM_SRCS*NUM_THREADS*32-1:0] in_data,
  output logic                            wb_valid,
  input  logic                            wb_ready,
  output logic [NW_BITS-1:0]              wb_wid,
  output logic [NUM_THREADS-1:0]          wb_tmask,
  output logic [31:0]                     wb_pc,
  output logic [4:0]                      wb_rd,
  output logic [NUM_THREADS*32-1:0]       wb_data,
  output logic                            wb_eop,
  output logic                            cmt_valid,
  output logic [$clog2(NUM_THREADS):0]    cmt_size
);

  localparam int PW = (NUM_SRCS > 1) ? $clog2(NUM_SRCS) : 1;
  localparam int CW = $clog2(NUM_THREADS) + 1;
  localparam int DW = NUM_THREADS * 32;

  logic [NW_BITS-1:0]     wid_a   [NUM_SRCS];
  logic [NUM_THREADS-1:0] tmask_a [NUM_SRCS];
  logic [31:0]            pc_a    [NUM_SRCS];
  logic [4:0]             rd_a    [NUM_SRCS];
  logic [DW-1:0]          data_a  [NUM_SRCS];

  for (genvar i = 0; i < NUM_SRCS; i++) begin : g_unpack
    assign wid_a[i]   = in_wid[i*NW_BITS +: NW_BITS];
    assign tmask_a[i] = in_tmask[i*NUM_THREADS +: NUM_THREADS];
    assign pc_a[i]    = in_pc[i*32 +: 32];
    assign rd_a[i]    = in_rd[i*5 +: 5];
    assign data_a[i]  = in_data[i*DW +: DW];
  end

  function automatic logic [CW-1:0] popcnt(input logic [NUM_THREADS-1:0] m);
    logic [CW-1:0] c;
    c = '0;
    for (int t = 0; t < NUM_THREADS; t++) c = c + CW'(m[t]);
    return c;
  endfunction

  logic [PW-1:0]          ptr_q, ptr_d;
  logic                   wb_valid_q, wb_valid_d;
  logic [NW_BITS-1:0]     wb_wid_q, wb_wid_d;
  logic [NUM_THREADS-1:0] wb_tmask_q, wb_tmask_d;
  logic [31:0]            wb_pc_q, wb_pc_d;
  logic [4:0]             wb_rd_q, wb_rd_d;
  logic [DW-1:0]          wb_data_q, wb_data_d;
  logic                   wb_eop_q, wb_eop_d;
  logic                   cmt_valid_q, cmt_valid_d;
  logic [CW-1:0]          cmt_size_q, cmt_size_d;

  logic                out_free;
  logic [NUM_SRCS-1:0] elig;
  logic                gnt_found;
  logic [PW-1:0]       gnt_idx;
  logic [PW:0]         idx;
  logic                gnt_wb;

  // Round-robin search from ptr; stores (wb=0) bypass the writeback stall.
  always_comb begin
    out_free  = !wb_valid_q || wb_ready;
    elig      = in_valid & ~(in_wb & {NUM_SRCS{!out_free}});
    gnt_found = 1'b0;
    gnt_idx   = '0;
    idx       = '0;
    in_ready  = '0;
    for (int k = 0; k < NUM_SRCS; k++) begin
      idx = {1'b0, ptr_q} + (PW+1)'(k);
      if (idx >= (PW+1)'(NUM_SRCS)) idx = idx - (PW+1)'(NUM_SRCS);
      if (!gnt_found && !reset && elig[idx[PW-1:0]]) begin
        gnt_found = 1'b1;
        gnt_idx   = idx[PW-1:0];
      end
    end
    if (gnt_found) in_ready[gnt_idx] = 1'b1;
  end

  always_comb begin
    gnt_wb     = gnt_found && in_wb[gnt_idx];
    ptr_d      = ptr_q;
    wb_valid_d = wb_valid_q;
    wb_wid_d   = wb_wid_q;
    wb_tmask_d = wb_tmask_q;
    wb_pc_d    = wb_pc_q;
    wb_rd_d    = wb_rd_q;
    wb_data_d  = wb_data_q;
    wb_eop_d   = wb_eop_q;
    if (gnt_found)
      ptr_d = (gnt_idx == PW'(NUM_SRCS-1)) ? '0 : gnt_idx + PW'(1);
    if (gnt_wb) begin
      wb_valid_d = 1'b1;
      wb_wid_d   = wid_a[gnt_idx];
      wb_tmask_d = tmask_a[gnt_idx];
      wb_pc_d    = pc_a[gnt_idx];
      wb_rd_d    = rd_a[gnt_idx];
      wb_data_d  = data_a[gnt_idx];
      wb_eop_d   = in_eop[gnt_idx];
    end else if (wb_ready) begin
      wb_valid_d = 1'b0;
    end
    cmt_valid_d = gnt_found && in_eop[gnt_idx];
    cmt_size_d  = cmt_valid_d ? popcnt(tmask_a[gnt_idx]) : '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q       <= '0;
      wb_valid_q  <= 1'b0;
      cmt_valid_q <= 1'b0;
      cmt_size_q  <= '0;
    end else begin
      ptr_q       <= ptr_d;
      wb_valid_q  <= wb_valid_d;
      cmt_valid_q <= cmt_valid_d;
      cmt_size_q  <= cmt_size_d;
    end
  end

  always_ff @(posedge clk) begin
    wb_wid_q   <= wb_wid_d;
    wb_tmask_q <= wb_tmask_d;
    wb_pc_q    <= wb_pc_d;
    wb_rd_q    <= wb_rd_d;
    wb_data_q  <= wb_data_d;
    wb_eop_q   <= wb_eop_d;
  end

  assign wb_valid  = wb_valid_q;
  assign wb_wid    = wb_wid_q;
  assign wb_tmask  = wb_tmask_q;
  assign wb_pc     = wb_pc_q;
  assign wb_rd     = wb_rd_q;
  assign wb_data   = wb_data_q;
  assign wb_eop    = wb_eop_q;
  assign cmt_valid = cmt_valid_q;
  assign cmt_size  = cmt_size_q;

endmodule

// File: tb/tb_vx_writeback_arb.sv
// Scoreboard bench for vx_writeback_arb: per-source input queues,
// expected grant/writeback/retire queues checked by a negedge monitor.
module tb_vx_writeback_arb;

  localparam int NS  = 6;
  localparam int NT  = 4;
  localparam int NWB = 2;
  localparam int DW  = NT * 32;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [NS-1:0]     in_valid, in_ready, in_wb, in_eop;
  logic [NS*NWB-1:0] in_wid;
  logic [NS*NT-1:0]  in_tmask;
  logic [NS*32-1:0]  in_pc;
  logic [NS*5-1:0]   in_rd;
  logic [NS*DW-1:0]  in_data;
  logic              wb_valid, wb_ready, wb_eop, cmt_valid;
  logic [NWB-1:0]    wb_wid;
  logic [NT-1:0]     wb_tmask;
  logic [31:0]       wb_pc;
  logic [4:0]        wb_rd;
  logic [DW-1:0]     wb_data;
  logic [2:0]        cmt_size;

  vx_writeback_arb dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_wid(in_wid), .in_tmask(in_tmask), .in_pc(in_pc),
    .in_rd(in_rd), .in_wb(in_wb), .in_eop(in_eop),
    .in_data(in_data),
    .wb_valid(wb_valid), .wb_ready(wb_ready),
    .wb_wid(wb_wid), .wb_tmask(wb_tmask), .wb_pc(wb_pc),
    .wb_rd(wb_rd), .wb_data(wb_data), .wb_eop(wb_eop),
    .cmt_valid(cmt_valid), .cmt_size(cmt_size)
  );

  typedef struct packed {
    logic [1:0]    wid;
    logic [3:0]    tmask;
    logic [31:0]   pc;
    logic [4:0]    rd;
    logic          wb;
    logic          eop;
    logic [DW-1:0] data;
  } cm_t;

  cm_t          srcq [NS][$];
  int           exp_gnt [$];
  logic [171:0] exp_wb [$];
  int           exp_cmt [$];

  int total = 0;
  int bad = 0;
  int wb_beats = 0;
  int cmt_cnt = 0;
  logic         prev_stall = 1'b0;
  logic [171:0] prev_pay;

  task automatic chk(string nm, logic [191:0] act, logic [191:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic logic [171:0] pay(cm_t c);
    return {c.wid, c.tmask, c.pc, c.rd, c.eop, c.data};
  endfunction

  function automatic cm_t mk(logic [1:0] w, logic [3:0] tm, logic [31:0] pc,
                             logic [4:0] rd, logic wb, logic eop);
    cm_t c;
    c.wid = w; c.tmask = tm; c.pc = pc; c.rd = rd;
    c.wb = wb; c.eop = eop;
    c.data = {$urandom, $urandom, $urandom, $urandom};
    return c;
  endfunction

  task automatic drive();
    for (int i = 0; i < NS; i++) begin
      if (srcq[i].size() > 0) begin
        in_valid[i]           = 1'b1;
        in_wid[i*NWB +: NWB]  = srcq[i][0].wid;
        in_tmask[i*NT +: NT]  = srcq[i][0].tmask;
        in_pc[i*32 +: 32]     = srcq[i][0].pc;
        in_rd[i*5 +: 5]       = srcq[i][0].rd;
        in_wb[i]              = srcq[i][0].wb;
        in_eop[i]             = srcq[i][0].eop;
        in_data[i*DW +: DW]   = srcq[i][0].data;
      end else begin
        in_valid[i] = 1'b0;
      end
    end
  endtask

  task automatic step(int n);
    logic [NS-1:0] acc;
    repeat (n) begin
      @(negedge clk);
      acc = in_valid & in_ready;
      @(posedge clk);
      #1;
      for (int i = 0; i < NS; i++)
        if (acc[i]) void'(srcq[i].pop_front());
      drive();
    end
  endtask

  task automatic push(int s, cm_t c, logic dropped, int sz);
    srcq[s].push_back(c);
    exp_gnt.push_back(s);
    if (c.wb && !dropped) exp_wb.push_back(pay(c));
    if (c.eop) exp_cmt.push_back(sz);
  endtask

  always @(negedge clk) begin
    if (!reset && in_ready != '0) begin
      chk("grant_onehot", 192'($onehot(in_ready)), 192'(1));
      chk("ready_has_valid", 192'(|(in_ready & in_valid)), 192'(1));
      for (int i = 0; i < NS; i++) begin
        if (in_ready[i]) begin
          if (exp_gnt.size() == 0) begin
            total++; bad++;
            $display("FAIL grant: got src %0d want none", i);
          end else begin
            chk("grant", 192'(i), 192'(exp_gnt.pop_front()));
          end
        end
      end
    end
    if (!reset && prev_stall)
      chk("hold", {wb_valid, wb_wid, wb_tmask, wb_pc, wb_rd, wb_eop, wb_data},
          {1'b1, prev_pay});
    prev_stall = !reset && wb_valid && !wb_ready;
    prev_pay   = {wb_wid, wb_tmask, wb_pc, wb_rd, wb_eop, wb_data};
    if (wb_valid && wb_ready) begin
      wb_beats++;
      if (exp_wb.size() == 0) begin
        total++; bad++;
        $display("FAIL wb_beat: got pc %0h want none", wb_pc);
      end else begin
        chk("wb_payload", {wb_wid, wb_tmask, wb_pc, wb_rd, wb_eop, wb_data},
            exp_wb.pop_front());
      end
    end
    if (cmt_valid) begin
      cmt_cnt++;
      if (exp_cmt.size() == 0) begin
        total++; bad++;
        $display("FAIL cmt: got size %0d want none", cmt_size);
      end else begin
        chk("cmt_size", 192'(cmt_size), 192'(exp_cmt.pop_front()));
      end
    end
  end

  initial begin
    cm_t c, c0, c2;
    int b0;
    logic [3:0] tm2 [7];
    int         sz2 [7];
    tm2 = '{4'b0001, 4'b0011, 4'b0111, 4'b1111, 4'b1010, 4'b0000, 4'b1100};
    sz2 = '{1, 2, 3, 4, 2, 0, 2};

    reset = 1'b1; wb_ready = 1'b1;
    in_valid = '1; in_wb = '1; in_eop = '1;
    in_wid = '0; in_tmask = '1; in_pc = '0; in_rd = '0; in_data = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_wb_valid", 192'(wb_valid), 192'(0));
    chk("rst_cmt_valid", 192'(cmt_valid), 192'(0));
    chk("rst_cmt_size", 192'(cmt_size), 192'(0));
    chk("rst_in_ready", 192'(in_ready), 192'(0));
    reset = 1'b0;
    drive();

    // single alu commit, 1-cycle latency
    c = mk(2'd1, 4'b1011, 32'h100, 5'd5, 1'b1, 1'b1);
    push(0, c, 1'b0, 3);
    drive();
    step(1);
    chk("t1_wb_valid", 192'(wb_valid), 192'(1));
    chk("t1_wb_rd", 192'(wb_rd), 192'(5));
    chk("t1_wb_wid", 192'(wb_wid), 192'(1));
    chk("t1_cmt_valid", 192'(cmt_valid), 192'(1));
    chk("t1_cmt_size", 192'(cmt_size), 192'(3));
    step(2);
    reset = 1'b1; step(2); reset = 1'b0;

    // all six sources, full throughput
    for (int i = 0; i < NS; i++)
      push(i, mk(2'(i), tm2[i], 32'h200 + 32'(i*4), 5'(i+1), 1'b1, 1'b1),
           1'b0, sz2[i]);
    push(0, mk(2'd3, tm2[6], 32'h300, 5'd9, 1'b1, 1'b1), 1'b0, sz2[6]);
    drive();
    step(1);
    b0 = wb_beats;
    step(7);
    chk("t2_beats", 192'(wb_beats - b0), 192'(7));
    step(2);

    // wrap from source 5 to source 0
    push(5, mk(2'd2, 4'b0101, 32'h400, 5'd10, 1'b1, 1'b0), 1'b0, 0);
    drive();
    step(1);
    push(0, mk(2'd0, 4'b0110, 32'h404, 5'd11, 1'b1, 1'b0), 1'b0, 0);
    push(5, mk(2'd1, 4'b0111, 32'h408, 5'd12, 1'b1, 1'b0), 1'b0, 0);
    drive();
    step(3);

    // multi-beat instruction retires once
    b0 = cmt_cnt;
    push(1, mk(2'd2, 4'b1111, 32'h500, 5'd13, 1'b1, 1'b0), 1'b0, 0);
    push(1, mk(2'd2, 4'b1111, 32'h500, 5'd14, 1'b1, 1'b1), 1'b0, 4);
    drive();
    step(4);
    chk("t5_cmt_count", 192'(cmt_cnt - b0), 192'(1));

    // backpressure: store passes, alu stalls
    wb_ready = 1'b0;
    c = mk(2'd3, 4'b0110, 32'h600, 5'd15, 1'b1, 1'b1);
    push(1, c, 1'b0, 2);
    drive();
    step(1);
    c0 = mk(2'd0, 4'b1000, 32'h604, 5'd16, 1'b1, 1'b1);
    c2 = mk(2'd1, 4'b0000, 32'h608, 5'd0, 1'b0, 1'b1);
    push(2, c2, 1'b0, 0);
    push(0, c0, 1'b0, 1);
    drive();
    step(1);
    chk("t3_alu_stalled", 192'(in_ready[0]), 192'(0));
    chk("t3_st_gone", 192'(in_valid[2]), 192'(0));
    step(3);
    chk("t3_pc_held", 192'(wb_pc), 192'(32'h600));
    wb_ready = 1'b1;
    step(1);
    chk("t3_alu_loaded", 192'(wb_pc), 192'(32'h604));
    step(1);

    // reset while a writeback is pending
    wb_ready = 1'b0;
    push(3, mk(2'd2, 4'b1111, 32'h700, 5'd17, 1'b1, 1'b1), 1'b1, 4);
    drive();
    step(1);
    chk("t6_pending", 192'(wb_valid), 192'(1));
    reset = 1'b1;
    push(2, mk(2'd1, 4'b0001, 32'h710, 5'd18, 1'b1, 1'b1), 1'b0, 1);
    push(4, mk(2'd0, 4'b0010, 32'h714, 5'd19, 1'b1, 1'b1), 1'b0, 1);
    drive();
    step(1);
    chk("t6_wb_valid", 192'(wb_valid), 192'(0));
    chk("t6_cmt_valid", 192'(cmt_valid), 192'(0));
    chk("t6_in_ready", 192'(in_ready), 192'(0));
    reset = 1'b0;
    wb_ready = 1'b1;
    #1;
    chk("t6_first_grant", 192'(in_ready), 192'(6'b000100));
    step(4);

    for (int k = 0; k < 20; k++)
      if (exp_gnt.size() + exp_wb.size() + exp_cmt.size() != 0) step(1);
    chk("left_gnt", 192'(exp_gnt.size()), 192'(0));
    chk("left_wb", 192'(exp_wb.size()), 192'(0));
    chk("left_cmt", 192'(exp_cmt.size()), 192'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
